// File: rtl/streaming_mult_pkg.sv
// Shared types and constants for the bit-serial multiplier sequencer.
// Imported by the controller and anything that needs its state encoding.
package streaming_mult_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction

endpackage

// File: rtl/streaming_mult_ctrl.sv
// Sequencer for the bit-serial multiplier core: takes an operand pair,
// clears the core, streams operands LSB-first and collects the product.
module streaming_mult_ctrl
  import streaming_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy,
  output logic               mult_clr,
  output logic               mult_en,
  output logic               mult_a_bit,
  output logic               mult_b_bit,
  input  logic               mult_p_bit
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [PW-1:0]    prod;
  logic [CW-1:0]    cnt;

  logic accept;
  logic shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    mult_clr   = 1'b0;
    mult_en    = 1'b0;
    mult_a_bit = 1'b0;
    mult_b_bit = 1'b0;
    accept     = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !abort) begin
          accept  = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        mult_clr = 1'b1;
        state_n  = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        mult_en    = 1'b1;
        mult_a_bit = a_sr[0];
        mult_b_bit = b_sr[0];
        shift      = !abort;
        if (cnt == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // abort outranks every handshake decided above
    if (abort) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      prod <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= in_a;
      b_sr <= in_b;
      prod <= '0;
      cnt  <= '0;
    end else if (state == CLEAR) begin
      cnt <= '0;
    end else if (shift) begin
      // zero fill gives the upper-half padding for free
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      prod <= {mult_p_bit, prod[PW-1:1]};
      cnt  <= cnt + 1'b1;
    end
  end

  assign out_product = prod;

endmodule
